sr_pixel_scheduler: RTL and testbench

- Sequences the super-resolution core over one stored frame.
- Walks pixel coordinates in raster order and fetches each 3x3 neighbourhood from the frame-buffer read port, with zero padding at the image edges.
- Starts the core, waits for its result, and pushes the result into the output FIFO under a high-water backpressure rule.
- Sits between the frame-buffer BRAM (port B), the superresolution core and the output asyn_fifo write side, all in one clock domain.

---
 rtl/sr_pkg.sv | 30 +++
 rtl/sr_nbhd_fetch.sv | 82 ++++++++
 rtl/sr_pixel_scheduler.sv | 145 ++++++++++++++
 tb/tb_sr_pixel_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and constants for the super-resolution pixel scheduler:
// FSM states, 3x3 tap offsets and a width helper.
package sr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_START,
    ST_WAIT,
    ST_PUSH,
    ST_DONE
  } sr_state_e;

  localparam int NTAPS  = 9;
  localparam int CENTER = 4;

  // Tap k sits at (DX[k], DY[k]) relative to the centre pixel.
  localparam logic signed [1:0] DX [0:8] = '{-2'sd1, 2'sd0, 2'sd1,
                                             -2'sd1, 2'sd0, 2'sd1,
                                             -2'sd1, 2'sd0, 2'sd1};
  localparam logic signed [1:0] DY [0:8] = '{-2'sd1, -2'sd1, -2'sd1,
                                              2'sd0,  2'sd0,  2'sd0,
                                              2'sd1,  2'sd1,  2'sd1};

  function automatic int clog2_safe(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sr_nbhd_fetch.sv
// Fetches one 3x3 neighbourhood: one tap per cycle while start is high,
// zero padding outside the frame, read data captured one cycle after issue.
module sr_nbhd_fetch import sr_pkg::*; #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int PIXEL_WIDTH = 24,
  parameter int ADDR_WIDTH  = 17,
  parameter int X_W         = 9,
  parameter int Y_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [X_W-1:0]           x,
  input  logic [Y_W-1:0]           y,
  input  logic [ADDR_WIDTH-1:0]    centre_addr,
  output logic                     done,
  output logic                     fb_rd_en,
  output logic [ADDR_WIDTH-1:0]    fb_rd_addr,
  input  logic [PIXEL_WIDTH-1:0]   fb_rd_data,
  output logic [9*PIXEL_WIDTH-1:0] nbhd
);

  // Handshake: start stays high for the nine tap cycles; done is high in the
  // last of them, after which start drops. The final capture lands one cycle later.
  localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT - 1);
  localparam logic signed [ADDR_WIDTH:0] W_S = (ADDR_WIDTH + 1)'(WIDTH);

  logic [3:0]             k_q, k_d;
  logic                   pend_q, pend_d;
  logic [3:0]             pend_k_q, pend_k_d;
  logic [PIXEL_WIDTH-1:0] slot_q [0:8];
  logic [PIXEL_WIDTH-1:0] slot_d [0:8];

  logic signed [1:0]          dx, dy;
  logic                       in_bounds;
  logic signed [ADDR_WIDTH:0] row_off, col_off, addr_sum;

  always_comb begin
    dx = DX[k_q];
    dy = DY[k_q];
    in_bounds = !((dx[1] && x == '0) || (dx == 2'sd1 && x == X_MAX) ||
                  (dy[1] && y == '0) || (dy == 2'sd1 && y == Y_MAX));
    row_off  = dy[1] ? -W_S : ((dy == 2'sd1) ? W_S : '0);
    col_off  = {{(ADDR_WIDTH - 1){dx[1]}}, dx};
    addr_sum = $signed({1'b0, centre_addr}) + row_off + col_off;

    fb_rd_en   = start && in_bounds;
    fb_rd_addr = fb_rd_en ? addr_sum[ADDR_WIDTH-1:0] : '0;
    done       = start && (k_q == 4'd8);

    k_d      = k_q;
    pend_d   = 1'b0;
    pend_k_d = k_q;
    slot_d   = slot_q;
    if (pend_q) slot_d[pend_k_q] = fb_rd_data;
    if (start) begin
      pend_d = in_bounds;
      if (!in_bounds) slot_d[k_q] = '0;
      k_d = (k_q == 4'd8) ? 4'd0 : k_q + 4'd1;
    end

    nbhd = '0;
    for (int i = 0; i < NTAPS; i++) nbhd[i*PIXEL_WIDTH +: PIXEL_WIDTH] = slot_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q      <= '0;
      pend_q   <= 1'b0;
      pend_k_q <= '0;
      slot_q   <= '{default: '0};
    end else begin
      k_q      <= k_d;
      pend_q   <= pend_d;
      pend_k_q <= pend_k_d;
      slot_q   <= slot_d;
    end
  end

endmodule

// File: rtl/sr_pixel_scheduler.sv
// Walks one frame in raster order: fetch neighbourhood, run the core,
// push the result to the output FIFO below the high-water mark.
module sr_pixel_scheduler import sr_pkg::*; #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int PIXEL_WIDTH = 24,
  parameter int ADDR_WIDTH  = 17,
  parameter int LEVEL_WIDTH = 10,
  parameter int HIGH_WATER  = 1000,
  localparam int X_W = clog2_safe(WIDTH),
  localparam int Y_W = clog2_safe(HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     fb_rd_en,
  output logic [ADDR_WIDTH-1:0]    fb_rd_addr,
  input  logic [PIXEL_WIDTH-1:0]   fb_rd_data,
  output logic                     sr_start,
  output logic [X_W-1:0]           sr_x,
  output logic [Y_W-1:0]           sr_y,
  output logic [9*PIXEL_WIDTH-1:0] sr_neighborhood,
  input  logic                     sr_pixel_done,
  input  logic [PIXEL_WIDTH-1:0]   sr_pixel_out,
  output logic                     fifo_write,
  output logic [PIXEL_WIDTH-1:0]   fifo_data,
  input  logic [LEVEL_WIDTH-1:0]   fifo_count,
  output sr_state_e                dbg_state
);

  localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT - 1);

  sr_state_e              state_q, state_d;
  logic [X_W-1:0]         x_q, x_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   sr_start_q, sr_start_d;
  logic                   fifo_write_q, fifo_write_d;
  logic [PIXEL_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic                   fetch_done;

  sr_nbhd_fetch #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIXEL_WIDTH(PIXEL_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .X_W(X_W), .Y_W(Y_W)
  ) u_fetch (
    .clk         (clk),
    .rst         (rst),
    .start       (state_q == ST_FETCH),
    .x           (x_q),
    .y           (y_q),
    .centre_addr (addr_q),
    .done        (fetch_done),
    .fb_rd_en    (fb_rd_en),
    .fb_rd_addr  (fb_rd_addr),
    .fb_rd_data  (fb_rd_data),
    .nbhd        (sr_neighborhood)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    busy_d       = busy_q;
    fifo_data_d  = fifo_data_q;
    frame_done_d = 1'b0;
    sr_start_d   = 1'b0;
    fifo_write_d = 1'b0;
    case (state_q)
      ST_IDLE: if (frame_ready) begin
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
        busy_d  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: if (fetch_done) state_d = ST_DRAIN;
      ST_DRAIN: begin
        sr_start_d = 1'b1;
        state_d    = ST_START;
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: if (sr_pixel_done) begin
        fifo_data_d = sr_pixel_out;
        state_d     = ST_PUSH;
      end
      ST_PUSH: if (int'(fifo_count) < HIGH_WATER) begin
        fifo_write_d = 1'b1;
        addr_d       = addr_q + 1'b1;
        if (x_q == X_MAX) begin
          x_d = '0;
          y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
        state_d = (x_q == X_MAX && y_q == Y_MAX) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      sr_start_q   <= 1'b0;
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      sr_start_q   <= sr_start_d;
      fifo_write_q <= fifo_write_d;
      fifo_data_q  <= fifo_data_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign sr_start   = sr_start_q;
  assign sr_x       = x_q;
  assign sr_y       = y_q;
  assign fifo_write = fifo_write_q;
  assign fifo_data  = fifo_data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sr_pixel_scheduler.sv
// Bench for sr_pixel_scheduler on a 4x3 frame whose BRAM holds value = address;
// the core model echoes the centre tap after a fixed latency.
module tb_sr_pixel_scheduler;
  import sr_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 24;
  localparam int AW = 17;
  localparam int LW = 10;
  localparam int HW = 1000;
  localparam int L  = 3;
  localparam int NB = 9 * PW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_ready = 1'b0;
  logic busy, frame_done, fb_rd_en, sr_start, fifo_write;
  logic [AW-1:0] fb_rd_addr;
  logic [PW-1:0] fb_rd_data = '0;
  logic [1:0] sr_x, sr_y;
  logic [NB-1:0] sr_neighborhood;
  logic sr_pixel_done = 1'b0;
  logic [PW-1:0] sr_pixel_out = '0;
  logic [PW-1:0] fifo_data;
  logic [LW-1:0] fifo_count = LW'(HW - 1);
  sr_state_e dbg_state;

  sr_pixel_scheduler #(
    .WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW),
    .LEVEL_WIDTH(LW), .HIGH_WATER(HW)
  ) dut (
    .clk(clk), .rst(rst), .frame_ready(frame_ready), .busy(busy),
    .frame_done(frame_done), .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr),
    .fb_rd_data(fb_rd_data), .sr_start(sr_start), .sr_x(sr_x), .sr_y(sr_y),
    .sr_neighborhood(sr_neighborhood), .sr_pixel_done(sr_pixel_done),
    .sr_pixel_out(sr_pixel_out), .fifo_write(fifo_write), .fifo_data(fifo_data),
    .fifo_count(fifo_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // BRAM model: value = address, one-cycle read latency
  always @(posedge clk) if (fb_rd_en) fb_rd_data <= PW'(fb_rd_addr);

  // core model: result = centre tap, done L cycles after the start cycle
  int core_cnt = 0;
  logic [PW-1:0] core_val = '0;
  logic extra_req = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      core_cnt = 0;
      sr_pixel_done = 1'b0;
    end else begin
      if (core_cnt > 0) core_cnt--;
      if (sr_start) begin
        core_cnt = L + 1;
        core_val = sr_neighborhood[CENTER*PW +: PW];
      end
      sr_pixel_done = (core_cnt == 1) || extra_req;
      extra_req = 1'b0;
      sr_pixel_out = core_val;
    end
  end

  // scoreboard and monitors
  logic [PW-1:0] exp_q[$];
  int wr_count = 0, done_count = 0, start_count = 0, unstable = 0, bad_addr = 0;
  int wr_times[$];
  logic [15:0] rd_mask = '0;
  int rd_cnt = 0;
  logic [NB-1:0] held_nbhd = '0;
  logic [NB-1:0] cap_nbhd [12];
  logic [15:0] cap_mask [12];
  int cap_cnt [12];

  always @(negedge clk) begin
    if (rst) begin
      rd_mask = '0;
      rd_cnt = 0;
    end else begin
      if (fb_rd_en) begin
        if (fb_rd_addr >= AW'(W * H)) bad_addr++;
        else rd_mask = rd_mask | (16'(1) << fb_rd_addr);
        rd_cnt++;
      end
      if (sr_start) begin
        int idx;
        idx = int'(sr_y) * W + int'(sr_x);
        if (idx < W * H) begin
          cap_nbhd[idx] = sr_neighborhood;
          cap_mask[idx] = rd_mask;
          cap_cnt[idx]  = rd_cnt;
        end
        held_nbhd = sr_neighborhood;
        rd_mask = '0;
        rd_cnt = 0;
        start_count++;
      end
      if (dbg_state == ST_WAIT && sr_neighborhood !== held_nbhd) unstable++;
      if (fifo_write) begin
        wr_count++;
        wr_times.push_back(cycle);
        if (exp_q.size() == 0) check("fifo_unexpected_write", 1, 0);
        else check("fifo_data", fifo_data, exp_q.pop_front());
      end
      if (frame_done) done_count++;
    end
  end

  // driver tasks
  task automatic pulse_ready();
    @(posedge clk); #2 frame_ready = 1'b1;
    @(posedge clk); #2 frame_ready = 1'b0;
  endtask

  task automatic new_frame();
    exp_q.delete();
    wr_times.delete();
    for (int i = 0; i < W * H; i++) exp_q.push_back(PW'(i));
    wr_count = 0;
    done_count = 0;
    start_count = 0;
  endtask

  task automatic wait_state(input sr_state_e s, input int max, input string name);
    int n = 0;
    while (dbg_state != s && n < max) begin @(negedge clk); n++; end
    check(name, dbg_state == s, 1'b1);
  endtask

  task automatic wait_frame_done(input string name);
    int n = 0;
    while (done_count < 1 && n < 2000) begin @(negedge clk); n++; end
    check(name, done_count >= 1, 1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_fb_rd_en"}, fb_rd_en, 0);
    check({tag, "_fb_rd_addr"}, fb_rd_addr, 0);
    check({tag, "_sr_start"}, sr_start, 0);
    check({tag, "_sr_xy"}, {sr_x, sr_y}, 0);
    check({tag, "_nbhd"}, sr_neighborhood, 0);
    check({tag, "_fifo_write"}, fifo_write, 0);
    check({tag, "_fifo_data"}, fifo_data, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  function automatic logic [NB-1:0] pack9(input int s0, s1, s2, s3, s4, s5, s6, s7, s8);
    int s [9];
    logic [NB-1:0] r;
    s = '{s0, s1, s2, s3, s4, s5, s6, s7, s8};
    r = '0;
    for (int i = 0; i < 9; i++) r[i*PW +: PW] = PW'(s[i]);
    return r;
  endfunction

  typedef struct {
    int            idx;
    logic [15:0]   mask;
    int            cnt;
    logic [NB-1:0] nb;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int d0_changed, w0;
    logic [PW-1:0] d0;
    int n;

    // pixel index, addresses read, read count, expected 3x3 slots
    vecs[0] = '{0,  16'h0033, 4, pack9(0, 0, 0, 0, 0, 1, 0, 4, 5)};
    vecs[1] = '{5,  16'h0777, 9, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10)};
    vecs[2] = '{11, 16'h0CC0, 4, pack9(6, 7, 0, 10, 11, 0, 0, 0, 0)};
    vecs[3] = '{3,  16'h00CC, 4, pack9(0, 0, 0, 2, 3, 0, 6, 7, 0)};
    vecs[4] = '{8,  16'h0330, 4, pack9(0, 4, 5, 0, 8, 9, 0, 0, 0)};

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // frame 1: fifo_count one below high water, extra frame_ready/done ignored
    new_frame();
    pulse_ready();
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    n = 0;
    while (wr_count < 1 && n < 200) begin @(negedge clk); n++; end
    check("first_write_seen", wr_count >= 1, 1);
    wait_state(ST_FETCH, 20, "reach_fetch");
    @(posedge clk); #2 frame_ready = 1'b1; extra_req = 1'b1;
    @(posedge clk); #2 frame_ready = 1'b0;
    wait_frame_done("frame1_done");
    check("frame1_writes", wr_count, W * H);
    check("frame1_done_pulses", done_count, 1);
    check("frame1_starts", start_count, W * H);
    check("frame1_busy_low", busy, 0);
    check("frame1_state_idle", dbg_state, ST_IDLE);
    check("frame1_exp_empty", exp_q.size(), 0);
    check("nbhd_stable_in_wait", unstable, 0);
    check("no_bad_addr", bad_addr, 0);
    for (int i = 1; i < wr_times.size(); i++)
      check("write_period", wr_times[i] - wr_times[i-1], 15);

    for (int v = 0; v < 5; v++) begin
      check($sformatf("nbhd_px%0d", vecs[v].idx), cap_nbhd[vecs[v].idx], vecs[v].nb);
      check($sformatf("rdmask_px%0d", vecs[v].idx), cap_mask[vecs[v].idx], vecs[v].mask);
      check($sformatf("rdcnt_px%0d", vecs[v].idx), cap_cnt[vecs[v].idx], vecs[v].cnt);
    end

    // frame 2: FIFO at high water stalls the first push for 50 cycles
    new_frame();
    fifo_count = LW'(HW);
    pulse_ready();
    wait_state(ST_PUSH, 100, "reach_push");
    d0 = fifo_data;
    w0 = wr_count;
    d0_changed = 0;
    repeat (50) begin
      @(negedge clk);
      if (fifo_data !== d0) d0_changed++;
    end
    check("stall_no_write", wr_count, w0);
    check("stall_data_held", d0_changed, 0);
    check("stall_state", dbg_state, ST_PUSH);
    fifo_count = LW'(HW - 1);
    @(negedge clk);
    check("release_write", fifo_write, 1);
    @(negedge clk);
    check("release_single", fifo_write, 0);
    wait_frame_done("frame2_done");
    check("frame2_writes", wr_count, W * H);
    check("frame2_done_pulses", done_count, 1);

    // frame 3: reset while waiting on the core at pixel 5
    new_frame();
    pulse_ready();
    n = 0;
    while (!(dbg_state == ST_WAIT && sr_x == 2'd1 && sr_y == 2'd1) && n < 400) begin
      @(negedge clk); n++;
    end
    check("reach_wait_px5", dbg_state == ST_WAIT && sr_x == 2'd1 && sr_y == 2'd1, 1);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk); #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midreset_no_resume", dbg_state, ST_IDLE);

    // frame 4: clean restart from (0,0)
    new_frame();
    pulse_ready();
    wait_frame_done("frame4_done");
    check("frame4_writes", wr_count, W * H);
    check("frame4_done_pulses", done_count, 1);
    check("frame4_nbhd_px0", cap_nbhd[0], vecs[0].nb);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1);
  end

endmodule
